ibex_wb_stage: RTL and testbench

- Writeback stage directly upstream of the register file write port. Merges single-cycle execute results with variable-latency load responses and registers one writeback per cycle onto the write port.
- Tracks one outstanding load destination as a scoreboard and raises read-after-write and write-after-write hazards.
- Forwards the in-flight writeback value onto both read-data paths so decode sees the newest value.

---
 rtl/ibex_wb_stage.sv | 110 +++++++++++
 tb/tb_ibex_wb_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_wb_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ibex_wb_stage : writeback stage merging execute results and load responses,
//                 with one-entry load scoreboard and read-data forwarding.
// Revision      : 1.0
// ----------------------------------------------------------------------------
module ibex_wb_stage #(
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 ld_issue_i,
  input  logic [4:0]           ld_waddr_i,
  output logic                 ld_issue_ready_o,
  input  logic                 lsu_rvalid_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  input  logic                 lsu_err_i,
  output logic                 ld_err_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  input  logic [DataWidth-1:0] rf_rdata_a_i,
  input  logic [DataWidth-1:0] rf_rdata_b_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] LOAD_PEND = 1'b1;

  logic [0:0]           state;
  logic [4:0]           pend_addr;
  logic                 wb_we;
  logic [4:0]           wb_addr;
  logic [DataWidth-1:0] wb_data;
  logic                 ld_err_q;

  logic pending;
  logic resp;
  logic ex_accept;

  assign pending   = (state == LOAD_PEND);
  // A response with nothing outstanding (e.g. after reset) is a stray and ignored.
  assign resp      = pending && lsu_rvalid_i;

  assign ld_issue_ready_o = !pending || lsu_rvalid_i;
  assign ex_ready_o = !lsu_rvalid_i &&
                      !(pending && (ex_waddr_i == pend_addr) && (ex_waddr_i != 5'd0));
  assign ex_accept  = ex_valid_i && ex_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      pend_addr <= 5'd0;
    end else if (ld_issue_i) begin
      state     <= LOAD_PEND;
      pend_addr <= ld_waddr_i;
    end else if (resp) begin
      state     <= IDLE;
    end
  end

  // Writes to x0 still take the slot (address/data load) but never enable the write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_we    <= 1'b0;
      wb_addr  <= 5'd0;
      wb_data  <= '0;
      ld_err_q <= 1'b0;
    end else begin
      ld_err_q <= resp && lsu_err_i;
      if (resp && !lsu_err_i) begin
        wb_we   <= (pend_addr != 5'd0);
        wb_addr <= pend_addr;
        wb_data <= lsu_rdata_i;
      end else if (ex_accept) begin
        wb_we   <= (ex_waddr_i != 5'd0);
        wb_addr <= ex_waddr_i;
        wb_data <= ex_wdata_i;
      end else begin
        wb_we   <= 1'b0;
      end
    end
  end

  assign rf_we_o    = wb_we;
  assign rf_waddr_o = wb_addr;
  assign rf_wdata_o = wb_data;
  assign ld_err_o   = ld_err_q;

  assign hazard_a_o = pending && (raddr_a_i == pend_addr) && (raddr_a_i != 5'd0) && !lsu_rvalid_i;
  assign hazard_b_o = pending && (raddr_b_i == pend_addr) && (raddr_b_i != 5'd0) && !lsu_rvalid_i;

  assign rdata_a_o = (wb_we && (wb_addr == raddr_a_i) && (raddr_a_i != 5'd0)) ? wb_data : rf_rdata_a_i;
  assign rdata_b_o = (wb_we && (wb_addr == raddr_b_i) && (raddr_b_i != 5'd0)) ? wb_data : rf_rdata_b_i;

  // Only one load may be outstanding; upstream must honour ld_issue_ready_o.
  issue_protocol : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    ld_issue_i |-> ld_issue_ready_o);

endmodule
`default_nettype wire

// File: tb/tb_ibex_wb_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ibex_wb_stage : directed self-checking bench for ibex_wb_stage.
// Revision         : 1.0
// ----------------------------------------------------------------------------
module tb_ibex_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic [4:0]  ex_waddr_i = '0;
  logic [31:0] ex_wdata_i = '0;
  logic        ex_ready_o;
  logic        ld_issue_i = 1'b0;
  logic [4:0]  ld_waddr_i = '0;
  logic        ld_issue_ready_o;
  logic        lsu_rvalid_i = 1'b0;
  logic [31:0] lsu_rdata_i = '0;
  logic        lsu_err_i = 1'b0;
  logic        ld_err_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [4:0]  raddr_a_i = '0;
  logic [4:0]  raddr_b_i = '0;
  logic [31:0] rf_rdata_a_i = '0;
  logic [31:0] rf_rdata_b_i = '0;
  logic [31:0] rdata_a_o;
  logic [31:0] rdata_b_o;
  logic        hazard_a_o;
  logic        hazard_b_o;

  int n_chk = 0;
  int n_fail = 0;

  ibex_wb_stage #(.DataWidth(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .ex_ready_o(ex_ready_o),
    .ld_issue_i(ld_issue_i), .ld_waddr_i(ld_waddr_i), .ld_issue_ready_o(ld_issue_ready_o),
    .lsu_rvalid_i(lsu_rvalid_i), .lsu_rdata_i(lsu_rdata_i), .lsu_err_i(lsu_err_i),
    .ld_err_o(ld_err_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
    .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i),
    .rdata_a_o(rdata_a_o), .rdata_b_o(rdata_b_o),
    .hazard_a_o(hazard_a_o), .hazard_b_o(hazard_b_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge so registered outputs are settled.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_we",    32'(rf_we_o), 32'd0);
    chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
    chk("rst_wdata", rf_wdata_o, 32'd0);
    chk("rst_lderr", 32'(ld_err_o), 32'd0);
    chk("rst_hazb",  32'(hazard_b_o), 32'd0);
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // Execute result and forwarding
    ex_valid_i = 1'b1; ex_waddr_i = 5'd5; ex_wdata_i = 32'hDEADBEEF;
    #1 chk("ex_ready", 32'(ex_ready_o), 32'd1);
    tick();
    ex_valid_i = 1'b0; raddr_a_i = 5'd5; rf_rdata_a_i = 32'h11111111;
    #1;
    chk("ex_we",    32'(rf_we_o), 32'd1);
    chk("ex_waddr", 32'(rf_waddr_o), 32'd5);
    chk("ex_wdata", rf_wdata_o, 32'hDEADBEEF);
    chk("ex_fwd_a", rdata_a_o, 32'hDEADBEEF);
    tick();
    chk("ex_we_off", 32'(rf_we_o), 32'd0);
    chk("ex_nofwd",  rdata_a_o, 32'h11111111);
    raddr_a_i = 5'd0;

    // Load to x7 with read hazard, response three cycles after issue
    ld_issue_i = 1'b1; ld_waddr_i = 5'd7;
    #1 chk("ld_rdy_idle", 32'(ld_issue_ready_o), 32'd1);
    tick();
    ld_issue_i = 1'b0; raddr_b_i = 5'd7; rf_rdata_b_i = 32'hAAAA0000;
    #1;
    chk("haz_b_1",   32'(hazard_b_o), 32'd1);
    chk("ld_rdy_pd", 32'(ld_issue_ready_o), 32'd0);
    tick();
    chk("haz_b_2", 32'(hazard_b_o), 32'd1);
    tick();
    lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h12345678;
    #1;
    chk("haz_b_resp", 32'(hazard_b_o), 32'd0);
    chk("ld_rdy_rsp", 32'(ld_issue_ready_o), 32'd1);
    tick();
    lsu_rvalid_i = 1'b0;
    #1;
    chk("ld_we",     32'(rf_we_o), 32'd1);
    chk("ld_waddr",  32'(rf_waddr_o), 32'd7);
    chk("ld_wdata",  rf_wdata_o, 32'h12345678);
    chk("ld_haz_b",  32'(hazard_b_o), 32'd0);
    chk("ld_fwd_b",  rdata_b_o, 32'h12345678);
    chk("ld_idle",   32'(ld_issue_ready_o), 32'd1);
    raddr_b_i = 5'd0;

    // Collision: response and execute to another register in the same cycle
    ld_issue_i = 1'b1; ld_waddr_i = 5'd3;
    tick();
    ld_issue_i = 1'b0; lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h33333333;
    ex_valid_i = 1'b1; ex_waddr_i = 5'd4; ex_wdata_i = 32'h44444444;
    #1 chk("col_exrdy0", 32'(ex_ready_o), 32'd0);
    tick();
    lsu_rvalid_i = 1'b0;
    #1;
    chk("col_waddr1", 32'(rf_waddr_o), 32'd3);
    chk("col_wdata1", rf_wdata_o, 32'h33333333);
    chk("col_exrdy1", 32'(ex_ready_o), 32'd1);
    tick();
    ex_valid_i = 1'b0;
    #1;
    chk("col_we2",    32'(rf_we_o), 32'd1);
    chk("col_waddr2", 32'(rf_waddr_o), 32'd4);
    chk("col_wdata2", rf_wdata_o, 32'h44444444);

    // WAW: execute to the pending load destination stalls until the response
    ld_issue_i = 1'b1; ld_waddr_i = 5'd9;
    tick();
    ld_issue_i = 1'b0; ex_valid_i = 1'b1; ex_waddr_i = 5'd9; ex_wdata_i = 32'h99990000;
    #1 chk("waw_rdy_a", 32'(ex_ready_o), 32'd0);
    tick();
    chk("waw_rdy_b", 32'(ex_ready_o), 32'd0);
    chk("waw_we0",   32'(rf_we_o), 32'd0);
    tick();
    lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h09090909;
    #1 chk("waw_rdy_c", 32'(ex_ready_o), 32'd0);
    tick();
    lsu_rvalid_i = 1'b0;
    #1;
    chk("waw_ld_addr", 32'(rf_waddr_o), 32'd9);
    chk("waw_ld_data", rf_wdata_o, 32'h09090909);
    chk("waw_rdy_d",   32'(ex_ready_o), 32'd1);
    tick();
    ex_valid_i = 1'b0;
    #1;
    chk("waw_ex_we",   32'(rf_we_o), 32'd1);
    chk("waw_ex_addr", 32'(rf_waddr_o), 32'd9);
    chk("waw_ex_data", rf_wdata_o, 32'h99990000);

    // Load error, then back-to-back issue during an error response
    ld_issue_i = 1'b1; ld_waddr_i = 5'd2;
    tick();
    ld_issue_i = 1'b0; lsu_rvalid_i = 1'b1; lsu_err_i = 1'b1; lsu_rdata_i = 32'h00000BAD;
    tick();
    lsu_rvalid_i = 1'b0; lsu_err_i = 1'b0;
    #1;
    chk("err_we",    32'(rf_we_o), 32'd0);
    chk("err_pulse", 32'(ld_err_o), 32'd1);
    chk("err_idle",  32'(ld_issue_ready_o), 32'd1);
    tick();
    chk("err_clear", 32'(ld_err_o), 32'd0);
    ld_issue_i = 1'b1; ld_waddr_i = 5'd2;
    tick();
    lsu_rvalid_i = 1'b1; lsu_err_i = 1'b1; ld_waddr_i = 5'd12;
    #1 chk("b2b_rdy", 32'(ld_issue_ready_o), 32'd1);
    tick();
    ld_issue_i = 1'b0; lsu_rvalid_i = 1'b0; lsu_err_i = 1'b0; raddr_a_i = 5'd12;
    #1;
    chk("b2b_err",  32'(ld_err_o), 32'd1);
    chk("b2b_we",   32'(rf_we_o), 32'd0);
    chk("b2b_haz",  32'(hazard_a_o), 32'd1);
    chk("b2b_pend", 32'(ld_issue_ready_o), 32'd0);
    lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h0C0C0C0C;
    tick();
    lsu_rvalid_i = 1'b0; raddr_a_i = 5'd0;
    #1;
    chk("b2b_ld_we",   32'(rf_we_o), 32'd1);
    chk("b2b_ld_addr", 32'(rf_waddr_o), 32'd12);

    // Execute write to x0: no enable, no forwarding, slot still loaded
    ex_valid_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'hFFFFFFFF;
    tick();
    ex_valid_i = 1'b0; raddr_a_i = 5'd0; rf_rdata_a_i = 32'h5A5A5A5A;
    #1;
    chk("x0_we",    32'(rf_we_o), 32'd0);
    chk("x0_waddr", 32'(rf_waddr_o), 32'd0);
    chk("x0_wdata", rf_wdata_o, 32'hFFFFFFFF);
    chk("x0_nofwd", rdata_a_o, 32'h5A5A5A5A);

    // Reset while a load is pending
    ld_issue_i = 1'b1; ld_waddr_i = 5'd6;
    tick();
    ld_issue_i = 1'b0; ex_valid_i = 1'b1; ex_waddr_i = 5'd8; ex_wdata_i = 32'h00000088;
    tick();
    ex_valid_i = 1'b0;
    #1 chk("pre_rst_we", 32'(rf_we_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_we",    32'(rf_we_o), 32'd0);
    chk("arst_waddr", 32'(rf_waddr_o), 32'd0);
    chk("arst_wdata", rf_wdata_o, 32'd0);
    chk("arst_idle",  32'(ld_issue_ready_o), 32'd1);
    tick();
    rst_ni = 1'b1;
    tick();
    lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h00000066;
    tick();
    lsu_rvalid_i = 1'b0;
    #1;
    chk("stray_we",    32'(rf_we_o), 32'd0);
    chk("stray_lderr", 32'(ld_err_o), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
